fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
- Parametrised single-clock FIFO. Successor to the fixed 4-bit FIFO behind the tile pins.
- Generalises data width and depth.
- Adds almost-full and almost-empty thresholds, an occupancy count, a registered read-valid strobe, and sticky overflow/underflow error flags.
- Instantiated inside the top-level tile wrapper. The wrapper maps it onto ui_in/uo_out/uio pins.

Parameters:
- DATA_W, 4: word width in bits, ≥1.
- DEPTH, 8: number of entries. Power of two, ≥2. AW = clog2(DEPTH).
- AF_LEVEL, 6: almost_full asserts when count ≥ AF_LEVEL. Range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL. Range 0..DEPTH-1.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: synchronous active-low reset.
- winc, input, 1: write request.
- wdata, input, DATA_W: write data.
- rinc, input, 1: read request.
- clr_err, input, 1: clears the sticky error flags.
- rdata, output, DATA_W: read data.
- rvalid, output, 1: rdata holds a freshly popped word.
- full, output, 1: count == DEPTH.
- empty, output, 1: count == 0.
- almost_full, output, 1: count ≥ AF_LEVEL.
- almost_empty, output, 1: count ≤ AE_LEVEL.
- count, output, AW+1: current occupancy, 0..DEPTH.
- overflow, output, 1: sticky; a write was rejected.
- underflow, output, 1: sticky; a read was rejected.

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-low: rst_n sampled low at a clk rising edge resets the block.
  - Pointers and count clear to 0.
  - rdata = 0, rvalid = 0, overflow = 0, underflow = 0.
  - Memory contents are not reset.
  - Post-reset outputs: empty = 1, full = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0 → never, since AF_LEVEL ≥ 1) = 0.
  - Reset mid-operation discards all contents. Any read pending in the same cycle does not produce rvalid.
- Pointers: wr_ptr and rd_ptr are AW+1 bits.
  - Address uses the low AW bits; the MSB is a wrap bit.
  - full = (addresses equal AND MSBs differ). empty = (pointers equal).
  - count = wr_ptr - rd_ptr, modulo 2^(AW+1).
- Write accept: wr_ok = winc & (!full | rd_ok).
  - On accept, mem[wr_ptr] ← wdata and wr_ptr increments.
- Read accept: rd_ok = rinc & !empty.
  - On accept, rdata ← mem[rd_ptr] at the same edge, rd_ptr increments, and rvalid = 1 for the following cycle.
  - Otherwise rvalid = 0 and rdata holds its last value.
  - Read latency: 1 cycle from the rinc edge.
- Simultaneous winc and rinc:
  - Not full, not empty: both accepted; count unchanged.
  - Full: both accepted. The read frees the slot the write consumes; no overflow.
  - Empty: write accepted, read rejected, underflow set. The new word is not bypassed to rdata.
- Error flags:
  - overflow ← 1 when winc & !wr_ok.
  - underflow ← 1 when rinc & !rd_ok.
  - Both are sticky until clr_err = 1 or reset.
  - If clr_err and a new error occur in the same cycle, set wins (flag = 1).
- Status flags full, empty, almost_full, almost_empty and count are all registered-state derived. They reflect accepted operations at the edge following the request.

Optional Feature:
- Macro: FIFO_FWFT_EN (first-word-fall-through).
- Defined:
  - rdata = mem[rd_ptr] combinationally whenever !empty; rvalid = !empty.
  - rinc pops the currently presented word; read latency is 0.
  - A word written into an empty FIFO appears on rdata the cycle after the write edge.
  - Simultaneous winc and rinc on empty: write accepted, read rejected (underflow set).
  - rdata is don't-care while empty.
- Undefined: registered read with 1-cycle latency and pulsed rvalid, as described above.
- All flag, count and error behaviour is identical in both builds.

Test Plan (DATA_W=4, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2):
- Reset, then write 0x1,0x2,0x3, then three reads → rvalid pulses with rdata 0x1,0x2,0x3, each 1 cycle after its rinc. empty=1 and count=0 at the end.
- Write 8 words 0x0..0x7 → full=1 after the 8th edge, almost_full rises after the 6th write, count=8. A 9th winc → overflow=1, count stays 8. clr_err → overflow=0.
- When full, assert winc=1 (0xA) and rinc=1 together → rdata=0x0, count stays 8, no overflow. Then drain 8 reads → the last word is 0xA and the pointers have wrapped.
- When empty, assert rinc=1 → underflow=1, rvalid=0. When empty, assert winc and rinc together (0x5) → count=1, underflow=1, next read returns 0x5.
- Fill to 5 words, pull rst_n low for 1 cycle with rinc=1 → count=0, empty=1, rvalid=0, errors cleared.
- FIFO_FWFT_EN build: write 0x9 into empty → rdata=0x9 and rvalid=1 the next cycle without rinc. rinc → empty=1 the next cycle.

Source files
------------

// File: rtl/fifo_sync_param_if.sv
// Handshake/status bundle for fifo_sync_param.
//   master: drives winc/wdata/rinc/clr_err and observes data and status.
//   slave : the FIFO itself; drives rdata/rvalid, full/empty, almost flags, count and error flags.
interface fifo_sync_param_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic              winc;
  logic [DATA_W-1:0] wdata;
  logic              rinc;
  logic              clr_err;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [AW:0]       count;
  logic              overflow;
  logic              underflow;

  modport master (
    output winc, wdata, rinc, clr_err,
    input  rdata, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc, clr_err,
    output rdata, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with almost-full/almost-empty thresholds, occupancy count,
// read-valid strobe and sticky overflow/underflow flags.
//
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - fifo_sync_param_if.slave: winc/wdata/rinc/clr_err in; rdata/rvalid, full/empty,
//           almost_full/almost_empty, count, overflow/underflow out
//
// Build option: define FIFO_FWFT_EN for first-word-fall-through reads (rdata shows the head
// word combinationally, rvalid = !empty). Default is a registered read with 1-cycle latency.
module fifo_sync_param #(
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 2
) (
  input logic               clk,
  input logic               rst_n,
  fifo_sync_param_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne  = 1;
  localparam logic [AW:0] AfLevel = AF_LEVEL[AW:0];
  localparam logic [AW:0] AeLevel = AE_LEVEL[AW:0];

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count;
  logic              full, empty;
  logic              wr_ok, rd_ok;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_comb begin
    count = wr_ptr_q - rd_ptr_q;
    // Same slot address but opposite wrap bits means the writer is a full lap ahead.
    full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    empty = (wr_ptr_q == rd_ptr_q);
    rd_ok = bus.rinc & ~empty;
    // A read in the same cycle frees the slot a write into a full FIFO needs.
    wr_ok = bus.winc & (~full | rd_ok);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PtrOne;
    if (rd_ok) rd_ptr_d = rd_ptr_q + PtrOne;

    // Set dominates a simultaneous clear.
    ovf_d = (ovf_q & ~bus.clr_err) | (bus.winc & ~wr_ok);
    udf_d = (udf_q & ~bus.clr_err) | (bus.rinc & ~rd_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is not reset; writes are blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.wdata;
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.rdata  = mem_q[rd_ptr_q[AW-1:0]];
  assign bus.rvalid = ~empty;
`else
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_ok;
      if (rd_ok) rdata_q <= mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
`endif

  assign bus.count        = count;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= AfLevel);
  assign bus.almost_empty = (count <= AeLevel);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param (DATA_W=4, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2).
module tb_fifo_sync_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_sync_param_if #(.DATA_W(4), .DEPTH(8)) bus ();

  fifo_sync_param #(
    .DATA_W  (4),
    .DEPTH   (8),
    .AF_LEVEL(6),
    .AE_LEVEL(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [3:0]  exp_q [$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a read word.
  always @(negedge clk) begin
    logic present;
`ifdef FIFO_FWFT_EN
    present = rst_n && bus.rinc && bus.rvalid;
`else
    present = bus.rvalid;
`endif
    if (present) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_read: got %0h expected no read", bus.rdata);
      end else begin
        check("rdata", {28'd0, bus.rdata}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] d);
    bus.winc  = 1'b1;
    bus.wdata = d;
    tick();
    bus.winc  = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] e);
    bus.rinc = 1'b1;
    exp_q.push_back(e);
    tick();
    bus.rinc = 1'b0;
  endtask

  initial begin
    bus.winc    = 1'b0;
    bus.wdata   = 4'h0;
    bus.rinc    = 1'b0;
    bus.clr_err = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_empty",   bus.empty, 1);
    check("rst_full",    bus.full, 0);
    check("rst_ae",      bus.almost_empty, 1);
    check("rst_af",      bus.almost_full, 0);
    check("rst_count",   bus.count, 0);
    check("rst_rvalid",  bus.rvalid, 0);
    check("rst_ovf",     bus.overflow, 0);
    check("rst_udf",     bus.underflow, 0);
`ifndef FIFO_FWFT_EN
    check("rst_rdata",   bus.rdata, 0);
`endif

    // Three writes then three reads
    do_write(4'h1);
    do_write(4'h2);
    check("ae_at_2", bus.almost_empty, 1);
    do_write(4'h3);
    check("ae_at_3", bus.almost_empty, 0);
    check("count_3", bus.count, 3);
    do_read(4'h1);
    check("rvalid_lat", bus.rvalid, 1);
    do_read(4'h2);
    do_read(4'h3);
    tick();
    check("drain_empty", bus.empty, 1);
    check("drain_count", bus.count, 0);

    // Fill to full, almost_full threshold, overflow
    for (int k = 0; k < 8; k++) begin
      do_write(4'(k));
      check("af_step", bus.almost_full, (k + 1 >= 6) ? 1 : 0);
      check("count_step", bus.count, k + 1);
    end
    check("full_8", bus.full, 1);
    do_write(4'hF);
    check("ovf_set", bus.overflow, 1);
    check("ovf_count", bus.count, 8);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check("ovf_clr", bus.overflow, 0);

    // Simultaneous write+read while full
    bus.winc  = 1'b1;
    bus.wdata = 4'hA;
    bus.rinc  = 1'b1;
    exp_q.push_back(4'h0);
    tick();
    bus.winc = 1'b0;
    bus.rinc = 1'b0;
    check("full_rw_count", bus.count, 8);
    check("full_rw_ovf",   bus.overflow, 0);
    check("full_rw_full",  bus.full, 1);
    for (int k = 1; k < 8; k++) do_read(4'(k));
    do_read(4'hA);
    tick();
    check("wrap_empty", bus.empty, 1);
    check("wrap_count", bus.count, 0);

    // Underflow on empty read
    bus.rinc = 1'b1;
    tick();
    bus.rinc = 1'b0;
    check("udf_set",    bus.underflow, 1);
    check("udf_rvalid", bus.rvalid, 0);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check("udf_clr", bus.underflow, 0);

    // Simultaneous write+read while empty: write only, no bypass
    bus.winc  = 1'b1;
    bus.wdata = 4'h5;
    bus.rinc  = 1'b1;
    tick();
    bus.winc = 1'b0;
    bus.rinc = 1'b0;
    check("empty_rw_count", bus.count, 1);
    check("empty_rw_udf",   bus.underflow, 1);
`ifndef FIFO_FWFT_EN
    check("empty_rw_nobypass", bus.rvalid, 0);
`endif
    do_read(4'h5);
    tick();
    check("after5_empty", bus.empty, 1);

    // Reset mid-operation with a pending read
    bus.rinc = 1'b1;
    tick();
    bus.rinc = 1'b0;
    check("pre_rst_udf", bus.underflow, 1);
    for (int k = 1; k <= 5; k++) do_write(4'(k));
    check("pre_rst_count", bus.count, 5);
    rst_n    = 1'b0;
    bus.rinc = 1'b1;
    tick();
    rst_n    = 1'b1;
    bus.rinc = 1'b0;
    check("mid_rst_count",  bus.count, 0);
    check("mid_rst_empty",  bus.empty, 1);
    check("mid_rst_rvalid", bus.rvalid, 0);
    check("mid_rst_udf",    bus.underflow, 0);
    check("mid_rst_ovf",    bus.overflow, 0);

`ifdef FIFO_FWFT_EN
    // First word falls through without rinc
    do_write(4'h9);
    check("fwft_rvalid", bus.rvalid, 1);
    check("fwft_rdata",  bus.rdata, 4'h9);
    do_read(4'h9);
    check("fwft_empty", bus.empty, 1);
`endif

    tick();
    tick();
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
